// File: rtl/memory_read_arbiter_pkg.sv
// Shared types for memory_read_arbiter: tag pipeline entry and one-hot index helper.
package memory_read_arbiter_pkg;

    // Upper bound on N_REQ; tag masks are sized to this and sliced by the top.
    localparam int unsigned MAX_REQ       = 16;
    localparam int unsigned MAX_REQ_IDX_W = $clog2(MAX_REQ);

    typedef struct packed {
        logic               valid;
        logic [MAX_REQ-1:0] mask;
    } tag_t;

    function automatic logic [MAX_REQ_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_REQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            if (oh[i]) idx = idx | MAX_REQ_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/memory_read_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index searching upward from rr_ptr+1.
module rr_picker
    import memory_read_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = IDX_W'((32'(rr_ptr) + 32'(k)) % N_REQ);
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
            end
        end
    end

    assign grant_idx = IDX_W'(onehot_to_idx(MAX_REQ'(grant)));

endmodule

// File: rtl/memory_read_arbiter.sv
// Round-robin read arbiter sharing one fixed-latency instruction RAM between N_REQ engines.
// Optional MEM_ARB_ADDR_MERGE_EN: eligible requesters with the winner's address share its read.
module memory_read_arbiter
    import memory_read_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ             = 4,
    parameter int unsigned MEMORY_WIDTH      = 20,
    parameter int unsigned MEMORY_ADDR_WIDTH = 11,
    parameter int unsigned MEM_LATENCY       = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_REQ-1:0]                   req_valid,
    input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]                   req_ready,
    output logic [MEMORY_WIDTH-1:0]            rsp_data,
    output logic                               mem_valid,
    output logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr,
    input  logic [MEMORY_WIDTH-1:0]            mem_data
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]             in_flight_q, in_flight_d;
    logic [N_REQ-1:0]             eligible, pick_oh, grant_mask;
    logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d, pick_idx;
    logic [MEMORY_ADDR_WIDTH-1:0] mem_addr_q, pick_addr;
    tag_t                         tag_q [MEM_LATENCY];
    tag_t                         tag_in, tag_tail;
    logic                         unused_tag_bits;

    // No grants while reset is asserted, so nothing enters the pipeline.
    assign eligible = rst ? '0 : (req_valid & ~in_flight_q);

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_oh),
        .grant_idx (pick_idx)
    );

    assign pick_addr = req_addr[pick_idx*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];

`ifdef MEM_ARB_ADDR_MERGE_EN
    always_comb begin
        grant_mask = pick_oh;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (eligible[i] && (req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH] == pick_addr)) begin
                grant_mask[i] = 1'b1;
            end
        end
    end
`else
    assign grant_mask = pick_oh;
`endif

    assign mem_valid = |pick_oh;
    assign mem_addr  = mem_valid ? pick_addr : mem_addr_q;
    assign rsp_data  = mem_data;

    assign tag_in.valid = mem_valid;
    assign tag_in.mask  = MAX_REQ'(grant_mask);
    assign tag_tail     = tag_q[MEM_LATENCY-1];

    assign req_ready       = tag_tail.valid ? tag_tail.mask[N_REQ-1:0] : '0;
    assign unused_tag_bits = ^tag_tail.mask;

    assign in_flight_d = (in_flight_q & ~req_ready) | grant_mask;
    assign rr_ptr_d    = mem_valid ? pick_idx : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= '0;
            rr_ptr_q    <= IDX_W'(N_REQ - 1);
            mem_addr_q  <= '0;
            for (int i = 0; i < int'(MEM_LATENCY); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            in_flight_q <= in_flight_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_addr_q  <= mem_addr;
            tag_q[0]    <= tag_in;
            for (int i = 1; i < int'(MEM_LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed scoreboard bench for memory_read_arbiter: one latency-1 and one latency-2 instance.
module tb_memory_read_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned MW = 20;
    localparam int unsigned AW = 11;

    typedef struct {
        int            cyc;
        logic [NR-1:0] mask;
        logic [MW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst1, rst2;
    logic [NR-1:0]    rv1, rv2, rdy1, rdy2;
    logic [NR*AW-1:0] ra1, ra2;
    logic [MW-1:0]    rsp1, rsp2, md1, md2;
    logic             mv1, mv2;
    logic [AW-1:0]    ma1, ma2, p1, p2a, p2b;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc;
    int   vectors;
    int   miscompares;
    bit   auto_drop;

    memory_read_arbiter #(
        .N_REQ (NR), .MEMORY_WIDTH (MW), .MEMORY_ADDR_WIDTH (AW), .MEM_LATENCY (1)
    ) u_dut1 (
        .clk (clk), .rst (rst1), .req_valid (rv1), .req_addr (ra1), .req_ready (rdy1),
        .rsp_data (rsp1), .mem_valid (mv1), .mem_addr (ma1), .mem_data (md1)
    );

    memory_read_arbiter #(
        .N_REQ (NR), .MEMORY_WIDTH (MW), .MEMORY_ADDR_WIDTH (AW), .MEM_LATENCY (2)
    ) u_dut2 (
        .clk (clk), .rst (rst2), .req_valid (rv2), .req_addr (ra2), .req_ready (rdy2),
        .rsp_data (rsp2), .mem_valid (mv2), .mem_addr (ma2), .mem_data (md2)
    );

    function automatic logic [MW-1:0] mem_word(input logic [AW-1:0] a);
        return {~a[8:0], a};
    endfunction

    // RAM models: data for an address appears MEM_LATENCY cycles after it was presented.
    always @(posedge clk) begin
        p1  <= ma1;
        p2a <= ma2;
        p2b <= p2a;
    end
    assign md1 = mem_word(p1);
    assign md2 = mem_word(p2b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_mem1(input logic v, input logic [AW-1:0] a);
        #1;
        check("mem_valid1", 32'(mv1), 32'(v));
        check("mem_addr1", 32'(ma1), 32'(a));
    endtask

    task automatic chk_mem2(input logic v, input logic [AW-1:0] a);
        #1;
        check("mem_valid2", 32'(mv2), 32'(v));
        check("mem_addr2", 32'(ma2), 32'(a));
    endtask

    task automatic push1(input int c, input logic [NR-1:0] m, input logic [AW-1:0] a);
        q1.push_back('{cyc: c, mask: m, data: mem_word(a)});
    endtask

    task automatic push2(input int c, input logic [NR-1:0] m, input logic [AW-1:0] a);
        q2.push_back('{cyc: c, mask: m, data: mem_word(a)});
    endtask

    task automatic set_addr1(input int i, input logic [AW-1:0] a);
        ra1[i*AW +: AW] = a;
    endtask

    task automatic set_addr2(input int i, input logic [AW-1:0] a);
        ra2[i*AW +: AW] = a;
    endtask

    // Compare both ready ports against the scoreboard at negedge, then advance one cycle.
    task automatic tick();
        logic [NR-1:0] em, seen1, seen2;
        logic [MW-1:0] ed;
        @(negedge clk);
        em = '0;
        ed = '0;
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            em = q1[0].mask;
            ed = q1[0].data;
            void'(q1.pop_front());
        end
        check("req_ready1", 32'(rdy1), 32'(em));
        if (em != '0) check("rsp_data1", 32'(rsp1), 32'(ed));
        em = '0;
        ed = '0;
        if (q2.size() > 0 && q2[0].cyc == cyc) begin
            em = q2[0].mask;
            ed = q2[0].data;
            void'(q2.pop_front());
        end
        check("req_ready2", 32'(rdy2), 32'(em));
        if (em != '0) check("rsp_data2", 32'(rsp2), 32'(ed));
        seen1 = rdy1;
        seen2 = rdy2;
        @(posedge clk);
        #1;
        cyc++;
        if (auto_drop) begin
            rv1 = rv1 & ~seen1;
            rv2 = rv2 & ~seen2;
        end
    endtask

    initial begin
        int t;
        cyc = 0; vectors = 0; miscompares = 0; auto_drop = 1'b0;
        rst1 = 1'b1; rst2 = 1'b1;
        rv1 = '0; rv2 = '0; ra1 = '0; ra2 = '0;

        // Reset state.
        @(posedge clk);
        #1;
        chk_mem1(1'b0, 11'h000);
        chk_mem2(1'b0, 11'h000);
        tick();
        tick();
        rst1 = 1'b0; rst2 = 1'b0;
        tick();

        // Full contention, latency 1: grants 0,1,2,3,0,1,2,3.
        t = cyc;
        rv1 = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr1(i, 11'(16 + i));
        for (int k = 0; k < 8; k++) begin
            chk_mem1(1'b1, 11'(16 + k % 4));
            push1(t + k + 1, 4'(1 << (k % 4)), 11'(16 + k % 4));
            tick();
        end
        rv1 = 4'b1000;
        chk_mem1(1'b0, 11'h013);
        tick();
        rv1 = '0;
        tick();

        // Fairness after idle: 2 alone, then 1 and 3 -> 3 before 1.
        auto_drop = 1'b1;
        t = cyc;
        set_addr1(2, 11'h022);
        rv1 = 4'b0100;
        chk_mem1(1'b1, 11'h022);
        push1(t + 1, 4'b0100, 11'h022);
        tick();
        set_addr1(1, 11'h021);
        set_addr1(3, 11'h023);
        rv1 = rv1 | 4'b1010;
        chk_mem1(1'b1, 11'h023);
        push1(t + 2, 4'b1000, 11'h023);
        tick();
        chk_mem1(1'b1, 11'h021);
        push1(t + 3, 4'b0010, 11'h021);
        tick();
        chk_mem1(1'b0, 11'h021);
        tick();
        tick();

        // Back-to-back: no grant in the ready cycle, next grant the cycle after.
        auto_drop = 1'b0;
        t = cyc;
        set_addr1(0, 11'h030);
        rv1 = 4'b0001;
        chk_mem1(1'b1, 11'h030);
        push1(t + 1, 4'b0001, 11'h030);
        tick();
        chk_mem1(1'b0, 11'h030);
        tick();
        set_addr1(0, 11'h031);
        chk_mem1(1'b1, 11'h031);
        push1(t + 3, 4'b0001, 11'h031);
        tick();
        chk_mem1(1'b0, 11'h031);
        tick();
        rv1 = '0;
        tick();

        // Requesters 1 and 3 at the same address.
        auto_drop = 1'b1;
        t = cyc;
        set_addr1(1, 11'h040);
        set_addr1(3, 11'h040);
        rv1 = 4'b1010;
`ifdef MEM_ARB_ADDR_MERGE_EN
        chk_mem1(1'b1, 11'h040);
        push1(t + 1, 4'b1010, 11'h040);
        tick();
        chk_mem1(1'b0, 11'h040);
        tick();
        tick();
`else
        chk_mem1(1'b1, 11'h040);
        push1(t + 1, 4'b0010, 11'h040);
        tick();
        chk_mem1(1'b1, 11'h040);
        push1(t + 2, 4'b1000, 11'h040);
        tick();
        chk_mem1(1'b0, 11'h040);
        tick();
        tick();
`endif

        // Single request, latency 2.
        t = cyc;
        set_addr2(0, 11'h005);
        rv2 = 4'b0001;
        chk_mem2(1'b1, 11'h005);
        push2(t + 2, 4'b0001, 11'h005);
        tick();
        chk_mem2(1'b0, 11'h005);
        tick();
        chk_mem2(1'b0, 11'h005);
        tick();
        tick();

        // Reset mid-flight, latency 2: lost read, then requester 0 first.
        t = cyc;
        set_addr2(0, 11'h00A);
        rv2 = 4'b0001;
        chk_mem2(1'b1, 11'h00A);
        tick();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        rv2 = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr2(i, 11'(80 + i));
        chk_mem2(1'b1, 11'h050);
        for (int i = 0; i < 4; i++) push2(t + 4 + i, 4'(1 << i), 11'(80 + i));
        for (int k = 0; k < 8; k++) tick();

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_read_arbiter.md
# memory_read_arbiter

Shares one single-port, fixed-latency instruction memory between N_REQ engines of the coprocessor array. Issues at most one read per cycle, chosen round-robin. Broadcasts read data to all requesters and signals the winner(s) with a per-requester ready pulse when the data is on the bus. Sits between the engines' memory read ports and the instruction RAM.

## Interface
- N_REQ, 4, number of requesting engines (≥2)
- MEMORY_WIDTH, 20, instruction word width
- MEMORY_ADDR_WIDTH, 11, memory address width
- MEM_LATENCY, 1, cycles from mem_valid to mem_data valid (≥1)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, clock `clk`
- req_valid  in  N_REQ  requester i wants a read; held with req_addr stable until req_ready[i]
- req_addr  in  N_REQ*MEMORY_ADDR_WIDTH  address of requester i in slice i
- req_ready  out  N_REQ  one-cycle pulse: rsp_data carries requester i's word this cycle
- rsp_data  out  MEMORY_WIDTH  broadcast read data, equals mem_data
- mem_valid  out  1  read strobe to RAM
- mem_addr  out  MEMORY_ADDR_WIDTH  read address to RAM
- mem_data  in  MEMORY_WIDTH  RAM read data, valid MEM_LATENCY cycles after mem_valid

## Operation
- Eligible mask: req_valid & ~in_flight.
- Each cycle with a non-zero eligible mask, grant one requester g, the first eligible index searching upward from rr_ptr+1 modulo N_REQ.
  - mem_valid=1 and mem_addr=req_addr[g], combinationally in the same cycle.
  - Set in_flight[g]. Set rr_ptr←g.
- A tag pipeline of MEM_LATENCY stages carries {valid, grant mask}. At its tail, req_ready = tail.mask when tail.valid, else 0.
- in_flight[i] clears at the end of the cycle in which req_ready[i]=1. Requester i is eligible again the next cycle.
- A requester that drops req_valid while in flight is a protocol violation. The response is still delivered.
- No eligible requester: mem_valid=0, mem_addr holds its last value, a bubble enters the pipeline, rr_ptr unchanged.
- rsp_data is always mem_data, pass-through. Requesters ignore it without ready.

## Timing
- Reset values:
  - req_ready=0, mem_valid=0, mem_addr=0.
  - rr_ptr=N_REQ-1, so after reset requester 0 has first priority.
  - in_flight=0, pipeline valids=0.
- Request-to-ready latency is exactly MEM_LATENCY cycles when granted immediately. Throughput is one read per cycle.
- All N_REQ requesting continuously with MEM_LATENCY=1: grants cycle 0,1,2,3,0,… Each requester gets one word per N_REQ cycles.
- Reset mid-operation: pipeline and in_flight are cleared and in-flight reads are lost. Memory data returning after reset produces no ready.
- A requester whose ready and new request fall in the same cycle waits one cycle (in_flight still set).

## Configuration
- MEM_ARB_ADDR_MERGE_EN
  - Defined: at grant, every eligible requester whose req_addr equals req_addr[g] is added to the grant mask. All of them get in_flight set and receive req_ready together. rr_ptr still advances to g only.
  - Undefined: the grant mask is always one-hot, and identical addresses are served by separate reads.

## Structure
- Shared package: tag pipeline entry typedef {logic valid; logic [N_REQ-1:0] mask}, plus a onehot-to-index function.
- One sub-module, rr_picker: combinational round-robin select from (eligible mask, rr_ptr) → one-hot grant plus index.
- Tag pipeline and in_flight register live in the top.

## Test plan
- Single request: N_REQ=4, MEM_LATENCY=2, req_valid=0001, addr 0x05 at cycle 0.
  - mem_valid/mem_addr=0x05 at cycle 0.
  - req_ready=0001 with rsp_data=M[0x05] at cycle 2. No other ready pulses.
- Full contention: all four requesting, addresses 0x10..0x13, latency 1.
  - Grants at cycles 0..3 in order 0,1,2,3. Readies at cycles 1..4.
  - Re-requests are granted in order 0,1,2,3 again.
- Fairness after idle: grant requester 2 alone, then requesters 1 and 3 both request.
  - Requester 3 is granted first, then requester 1.
- Back-to-back same requester: requester 0 re-asserts a new address the cycle after its ready.
  - The next grant occurs that cycle. There is no grant during the ready cycle.
- Merge (macro on): requesters 1 and 3 both at address 0x40.
  - One mem_valid. req_ready=1010 in the same cycle.
  - With the macro off: two reads, readies one cycle apart.
- Reset mid-flight: rst at cycle 1 after a grant at cycle 0, latency 2.
  - No req_ready at cycle 2.
  - Requester 0 has priority at the first cycle after reset.
